// File: rtl/btb_ctrl_if.sv
// Fetch/execute request bundle and BTB SRAM port bundle.
// Slave side is the controller; master side is fetch, execute and SRAM.
interface btb_ctrl_if #(
  parameter int IDX_W = 8
);
  logic             flush;
  logic             lkp_valid;
  logic [31:0]      lkp_pc;
  logic             pred_valid;
  logic             pred_hit;
  logic [31:0]      pred_target;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [31:0]      upd_target;
  logic             upd_taken;
  logic             sram_csb0;
  logic [IDX_W-1:0] sram_addr0;
  logic [31:0]      sram_din0;
  logic             sram_csb1;
  logic [IDX_W-1:0] sram_addr1;
  logic [31:0]      sram_dout1;

  modport slave (
    input  flush,
    input  lkp_valid,
    input  lkp_pc,
    output pred_valid,
    output pred_hit,
    output pred_target,
    input  upd_valid,
    input  upd_pc,
    input  upd_target,
    input  upd_taken,
    output sram_csb0,
    output sram_addr0,
    output sram_din0,
    output sram_csb1,
    output sram_addr1,
    input  sram_dout1
  );

  modport master (
    output flush,
    output lkp_valid,
    output lkp_pc,
    input  pred_valid,
    input  pred_hit,
    input  pred_target,
    output upd_valid,
    output upd_pc,
    output upd_target,
    output upd_taken,
    input  sram_csb0,
    input  sram_addr0,
    input  sram_din0,
    input  sram_csb1,
    input  sram_addr1,
    output sram_dout1
  );
endinterface

// File: rtl/btb_ctrl.sv
// Direct-mapped branch target buffer controller: valid bits in flops,
// tag/offset entries in an external SRAM with one-cycle write forwarding.
module btb_ctrl #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 10,
  parameter int OFS_W = 22
) (
  input logic        clk,
  input logic        rst_n,
  btb_ctrl_if.slave  bus
);
  localparam int TAG_LSB = IDX_W + 2;
  localparam int TAG_MSB = IDX_W + TAG_W + 1;
  localparam int REG_LSB = OFS_W + 2;
  localparam int REG_W   = 32 - REG_LSB;
  localparam int NENT    = 1 << IDX_W;

  logic [NENT-1:0]  valid_q, valid_d;
  logic             lkp_v_q, lkp_v_d;
  logic [IDX_W-1:0] lkp_idx_q, lkp_idx_d;
  logic [TAG_W-1:0] lkp_tag_q, lkp_tag_d;
  logic [REG_W-1:0] lkp_reg_q, lkp_reg_d;
  logic             fwd_v_q, fwd_v_d;
  logic [IDX_W-1:0] fwd_idx_q, fwd_idx_d;
  logic [31:0]      fwd_ent_q, fwd_ent_d;

  logic [IDX_W-1:0] lkp_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [31:0]      upd_ent;
  logic             same_reg;
  logic             upd_ok;
  logic             alloc;
  logic             inval;
  logic [31:0]      entry;
  logic             hit;
  logic             unused_bits;

  assign lkp_idx  = bus.lkp_pc[TAG_LSB-1:2];
  assign upd_idx  = bus.upd_pc[TAG_LSB-1:2];
  assign upd_ent  = {bus.upd_pc[TAG_MSB:TAG_LSB],
                     bus.upd_target[OFS_W+1:2]};
  assign same_reg = bus.upd_target[31:REG_LSB]
                 == bus.upd_pc[31:REG_LSB];
  assign upd_ok   = rst_n & bus.upd_valid & ~bus.flush;
  assign alloc    = upd_ok & bus.upd_taken & same_reg;
  assign inval    = upd_ok & ~alloc;

  assign unused_bits = ^{bus.lkp_pc, bus.upd_pc, bus.upd_target};

  always_comb begin
    valid_d   = valid_q;
    lkp_v_d   = bus.lkp_valid;
    lkp_idx_d = lkp_idx;
    lkp_tag_d = bus.lkp_pc[TAG_MSB:TAG_LSB];
    lkp_reg_d = bus.lkp_pc[31:REG_LSB];
    fwd_v_d   = alloc;
    fwd_idx_d = upd_idx;
    fwd_ent_d = upd_ent;
    if (bus.flush) begin
      valid_d = '0;
    end else if (alloc) begin
      valid_d[upd_idx] = 1'b1;
    end else if (inval) begin
      valid_d[upd_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      lkp_v_q   <= 1'b0;
      lkp_idx_q <= '0;
      lkp_tag_q <= '0;
      lkp_reg_q <= '0;
      fwd_v_q   <= 1'b0;
      fwd_idx_q <= '0;
      fwd_ent_q <= '0;
    end else begin
      valid_q   <= valid_d;
      lkp_v_q   <= lkp_v_d;
      lkp_idx_q <= lkp_idx_d;
      lkp_tag_q <= lkp_tag_d;
      lkp_reg_q <= lkp_reg_d;
      fwd_v_q   <= fwd_v_d;
      fwd_idx_q <= fwd_idx_d;
      fwd_ent_q <= fwd_ent_d;
    end
  end

  // SRAM array lags the write by one edge; the held update covers it
  always_comb begin
    entry = bus.sram_dout1;
    if (fwd_v_q && fwd_idx_q == lkp_idx_q) begin
      entry = fwd_ent_q;
    end
    hit = lkp_v_q & valid_q[lkp_idx_q]
        & (entry[31:OFS_W] == lkp_tag_q);
  end

  assign bus.pred_valid  = lkp_v_q;
  assign bus.pred_hit    = hit;
  assign bus.pred_target = hit
    ? {lkp_reg_q, entry[OFS_W-1:0], 2'b00} : '0;

  assign bus.sram_csb0  = ~alloc;
  assign bus.sram_addr0 = upd_idx;
  assign bus.sram_din0  = upd_ent;
  assign bus.sram_csb1  = ~(rst_n & bus.lkp_valid);
  assign bus.sram_addr1 = lkp_idx;
endmodule

// File: tb/tb_btb_ctrl.sv
// Randomized bench for btb_ctrl with an SRAM model and an
// architectural BTB map as the reference.
module tb_btb_ctrl;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  logic obs_csb0;

  btb_ctrl_if bus ();

  btb_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM: write registered at one edge, array updated at the next
  logic [31:0] mem [256];
  logic [7:0]  raddr;
  logic        wpend;
  logic [7:0]  waddr;
  logic [31:0] wdata;

  always @(posedge clk) begin
    if (wpend) mem[waddr] <= wdata;
    wpend <= !bus.sram_csb0;
    waddr <= bus.sram_addr0;
    wdata <= bus.sram_din0;
    if (!bus.sram_csb1) raddr <= bus.sram_addr1;
  end

  assign bus.sram_dout1 = mem[raddr];

  // architectural BTB contents as seen by the fetch side
  bit          ref_v   [256];
  logic [9:0]  ref_tag [256];
  logic [21:0] ref_ofs [256];
  logic        exp_pv;
  logic        exp_hit;
  logic [31:0] exp_tgt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic f,
                     input logic lv, input logic [31:0] lpc,
                     input logic uv, input logic [31:0] upc,
                     input logic [31:0] utgt, input logic ut);
    logic alloc;
    int   ui;
    int   li;
    rst_n          = r;
    bus.flush      = f;
    bus.lkp_valid  = lv;
    bus.lkp_pc     = lpc;
    bus.upd_valid  = uv;
    bus.upd_pc     = upc;
    bus.upd_target = utgt;
    bus.upd_taken  = ut;
    #1;
    alloc = r && uv && !f && ut && (utgt[31:24] == upc[31:24]);
    chk("csb0", 32'(bus.sram_csb0), 32'(!alloc));
    if (alloc) begin
      chk("addr0", 32'(bus.sram_addr0), 32'(upc[9:2]));
      chk("din0", bus.sram_din0, {upc[19:10], utgt[23:2]});
    end
    chk("csb1", 32'(bus.sram_csb1), 32'(!(r && lv)));
    if (r && lv) chk("addr1", 32'(bus.sram_addr1), 32'(lpc[9:2]));
    obs_csb0 = bus.sram_csb0;
    ui = int'(upc[9:2]);
    li = int'(lpc[9:2]);
    if (!r) begin
      foreach (ref_v[i]) ref_v[i] = 1'b0;
      exp_pv = 1'b0;
      exp_hit = 1'b0;
      exp_tgt = '0;
    end else begin
      if (f) begin
        foreach (ref_v[i]) ref_v[i] = 1'b0;
      end else if (uv) begin
        ref_v[ui] = alloc;
        if (alloc) begin
          ref_tag[ui] = upc[19:10];
          ref_ofs[ui] = utgt[23:2];
        end
      end
      exp_pv  = lv;
      exp_hit = lv && ref_v[li] && ref_tag[li] == lpc[19:10];
      exp_tgt = exp_hit ? {lpc[31:24], ref_ofs[li], 2'b00} : '0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("pred_valid", 32'(bus.pred_valid), 32'(exp_pv));
    chk("pred_hit", 32'(bus.pred_hit), 32'(exp_hit));
    chk("pred_target", bus.pred_target, exp_tgt);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic look(input logic [31:0] pc);
    cyc(1, 0, 1, pc, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] t,
                     input logic tk);
    cyc(1, 0, 0, 0, 1, pc, t, tk);
  endtask

  function automatic logic [31:0] rpc();
    logic [31:0] p;
    p = $urandom;
    p[1:0]   = 2'b00;
    p[9:2]   = 8'($urandom_range(0, 3));
    p[19:10] = ($urandom_range(0, 1) != 0) ? 10'h004 : 10'h005;
    p[31:24] = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
    return p;
  endfunction

  initial begin
    n_chk = 0;
    n_err = 0;
    raddr = '0;
    wpend = 1'b0;
    foreach (mem[i]) mem[i] = $urandom;
    foreach (ref_v[i]) ref_v[i] = 1'b0;

    // reset with requests presented: all ignored
    cyc(0, 0, 1, 32'h1000, 1, 32'h1000, 32'h2040, 1);
    chk("rst_csb0", 32'(obs_csb0), 32'd1);
    cyc(0, 0, 1, 32'h1000, 1, 32'h1000, 32'h2040, 1);
    chk("rst_pv", 32'(bus.pred_valid), 32'd0);
    chk("rst_tgt", bus.pred_target, 32'd0);

    look(32'h1000);
    chk("s1_pv", 32'(bus.pred_valid), 32'd1);
    chk("s1_hit", 32'(bus.pred_hit), 32'd0);

    upd(32'h1000, 32'h2040, 1);
    idle();
    look(32'h1000);
    chk("s2_hit", 32'(bus.pred_hit), 32'd1);
    chk("s2_tgt", bus.pred_target, 32'h0000_2040);
    look(32'h0004_1000);
    chk("s2_alias", 32'(bus.pred_hit), 32'd0);

    cyc(1, 0, 1, 32'h1004, 1, 32'h1004, 32'h3000, 1);
    chk("s3_hit", 32'(bus.pred_hit), 32'd1);
    chk("s3_tgt", bus.pred_target, 32'h0000_3000);

    upd(32'h1000, 32'h2040, 0);
    chk("s4_csb0", 32'(obs_csb0), 32'd1);
    look(32'h1000);
    chk("s4_hit", 32'(bus.pred_hit), 32'd0);

    upd(32'h1000, 32'h2040, 1);
    upd(32'h1000, 32'h0100_0000, 1);
    chk("s5_csb0", 32'(obs_csb0), 32'd1);
    look(32'h1000);
    chk("s5_hit", 32'(bus.pred_hit), 32'd0);

    upd(32'h1000, 32'h2040, 1);
    cyc(1, 1, 1, 32'h1000, 1, 32'h1008, 32'h2000, 1);
    chk("s6_csb0", 32'(obs_csb0), 32'd1);
    chk("s6_hit", 32'(bus.pred_hit), 32'd0);
    look(32'h1004);
    chk("s6_miss4", 32'(bus.pred_hit), 32'd0);
    look(32'h1008);
    chk("s6_miss8", 32'(bus.pred_hit), 32'd0);

    upd(32'h1004, 32'h3000, 1);
    look(32'h1004);
    chk("s6_rehit", 32'(bus.pred_hit), 32'd1);
    cyc(0, 0, 1, 32'h1004, 0, 0, 0, 0);
    chk("s6_rst_pv", 32'(bus.pred_valid), 32'd0);
    look(32'h1004);
    chk("s6_rst_miss", 32'(bus.pred_hit), 32'd0);

    for (int k = 0; k < 3000; k++) begin
      logic [31:0] up;
      logic [31:0] ut;
      up = rpc();
      ut = rpc();
      if ($urandom_range(0, 3) != 0) ut[31:24] = up[31:24];
      cyc($urandom_range(0, 149) != 0,
          $urandom_range(0, 59) == 0,
          $urandom_range(0, 3) != 0, rpc(),
          $urandom_range(0, 2) != 0, up, ut,
          $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
